// File: rtl/bambu_host_pkg.sv
// Shared types and defaults for the Bambu slave-port host driver.
// Op and state encodings plus timeout and counter-width constants.
package bambu_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RUN   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEM_WR    = 3'd1,
    MEM_RD    = 3'd2,
    RUN_START = 3'd3,
    RUN_WAIT  = 3'd4,
    RESP      = 3'd5
  } state_e;

  localparam int unsigned DEF_MEM_TIMEOUT = 64;
  localparam int unsigned DEF_RUN_TIMEOUT = 200000000;
  localparam int unsigned CNT_W           = 32;
  localparam int unsigned RSP_W           = 32;

endpackage

// File: rtl/bambu_timeout_counter.sv
// Loadable saturating up-counter with a ">= limit" flag.
// A load wins over an increment; the count sticks at all-ones.
module bambu_timeout_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q >= limit);

endmodule

// File: rtl/bambu_slave_host_driver.sv
// Host-side initiator for a Bambu `main` accelerator: executes WRITE/READ
// byte commands on slave channel 0 and RUN commands on the start/done pair.
module bambu_slave_host_driver
  import bambu_host_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SIZE_W      = 4,
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int unsigned RUN_TIMEOUT = DEF_RUN_TIMEOUT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_err,
  output logic [RSP_W-1:0]             rsp_data,
  output logic                         start_port,
  input  logic                         done_port,
  output logic [CHANNELS-1:0]          S_oe_ram,
  output logic [CHANNELS-1:0]          S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0]   S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]          Sout_DataRdy,
  output logic                         busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [RSP_W-1:0]    rsp_data_q, rsp_data_d;

  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_load_val;
  logic                cnt_inc;
  logic [CNT_W-1:0]    cnt_limit;
  logic [CNT_W-1:0]    cnt_count;
  logic                cnt_at_limit;

  logic                mem_rdy;
  logic [DATA_W-1:0]   mem_rdata;
  logic                in_mem;

  assign mem_rdy   = Sout_DataRdy[0];
  assign mem_rdata = Sout_Rdata_ram[DATA_W-1:0];
  assign in_mem    = (state_q == MEM_WR) || (state_q == MEM_RD);

  // Only one wait path is live at a time, so one counter serves both limits.
  assign cnt_limit = in_mem ? CNT_W'(MEM_TIMEOUT) : CNT_W'(RUN_TIMEOUT);

  bambu_timeout_counter #(
    .WIDTH (CNT_W)
  ) u_wait_cnt (
    .clk      (clock),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (cnt_inc),
    .limit    (cnt_limit),
    .count    (cnt_count),
    .at_limit (cnt_at_limit)
  );

  // Upper channels are never driven, so their return paths are don't-care.
  generate
    if (CHANNELS > 1) begin : g_upper_channels
      logic unused_upper;
      assign unused_upper = ^{Sout_Rdata_ram[CHANNELS*DATA_W-1:DATA_W],
                              Sout_DataRdy[CHANNELS-1:1]};
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d       = cmd_addr;
          wdata_d      = cmd_data;
          rsp_err_d    = 1'b0;
          rsp_data_d   = '0;
          // Count is 1 in the first cycle of the access or of the run.
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(1);
          unique case (op_e'(cmd_op))
            OP_WRITE: state_d = MEM_WR;
            OP_READ:  state_d = MEM_RD;
            OP_RUN:   state_d = RUN_START;
            default: begin
              rsp_err_d = 1'b1;
              state_d   = RESP;
            end
          endcase
        end
      end

      MEM_WR, MEM_RD: begin
        cnt_inc = 1'b1;
        if (mem_rdy) begin
          if (state_q == MEM_RD) begin
            rsp_data_d = RSP_W'(mem_rdata);
          end
          state_d = RESP;
        end else if (cnt_at_limit) begin
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end
      end

      RUN_START, RUN_WAIT: begin
        cnt_inc = 1'b1;
        if (done_port) begin
          rsp_data_d = RSP_W'(cnt_count);
          state_d    = RESP;
        end else if (cnt_at_limit) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = RSP_W'(RUN_TIMEOUT);
          state_d    = RESP;
        end else begin
          state_d = RUN_WAIT;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready       = (state_q == IDLE);
    busy            = (state_q != IDLE);
    rsp_valid       = (state_q == RESP);
    rsp_err         = rsp_err_q;
    rsp_data        = rsp_data_q;
    start_port      = (state_q == RUN_START);
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    if (in_mem) begin
      S_addr_ram[ADDR_W-1:0]      = addr_q;
      S_data_ram_size[SIZE_W-1:0] = SIZE_W'(DATA_W);
      if (state_q == MEM_WR) begin
        S_we_ram[0]                = 1'b1;
        S_Wdata_ram[DATA_W-1:0]    = wdata_q;
      end else begin
        S_oe_ram[0]                = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bambu_slave_host_driver.sv
// Directed bench for bambu_slave_host_driver: memory and accelerator models,
// with a queue-based scoreboard checking every response handshake.
module tb_bambu_slave_host_driver;

  localparam int CH   = 2;
  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int SW   = 4;
  localparam int MTO  = 64;
  localparam int RTO  = 50;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [AW-1:0]     cmd_addr = '0;
  logic [DW-1:0]     cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic              rsp_err;
  logic [31:0]       rsp_data;
  logic              start_port;
  logic              done_port = 1'b0;
  logic [CH-1:0]     S_oe_ram;
  logic [CH-1:0]     S_we_ram;
  logic [CH*AW-1:0]  S_addr_ram;
  logic [CH*DW-1:0]  S_Wdata_ram;
  logic [CH*SW-1:0]  S_data_ram_size;
  logic [CH*DW-1:0]  Sout_Rdata_ram = '0;
  logic [CH-1:0]     Sout_DataRdy = '0;
  logic              busy;

  always #5 clock = ~clock;

  bambu_slave_host_driver #(
    .CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW),
    .MEM_TIMEOUT(MTO), .RUN_TIMEOUT(RTO)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .start_port(start_port), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy), .busy(busy)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model knobs: -1 means never respond.
  int          mem_delay = 0;
  int          run_delay = 0;
  logic [6:0]  exp_addr  = '0;
  logic [7:0]  exp_wdata = '0;

  // Slave memory model: DataRdy arrives mem_delay cycles into the request.
  logic [7:0] mem [128];
  int         req_n = 0;
  always @(negedge clock) begin
    Sout_DataRdy[1]     <= 1'b1;
    Sout_Rdata_ram[15:8] <= 8'hFF;
    if (S_we_ram[0] || S_oe_ram[0]) begin
      req_n <= req_n + 1;
      Sout_DataRdy[0]     <= (mem_delay >= 0) && (req_n == mem_delay);
      Sout_Rdata_ram[7:0] <= mem[S_addr_ram[6:0]];
      if (S_we_ram[0] && (req_n == mem_delay)) mem[S_addr_ram[6:0]] <= S_Wdata_ram[7:0];
    end else begin
      req_n           <= 0;
      Sout_DataRdy[0] <= 1'b0;
    end
  end

  // Accelerator model: done_port pulses run_delay cycles after the start cycle.
  logic running = 1'b0;
  int   run_n   = 0;
  always @(negedge clock) begin
    done_port <= 1'b0;
    if (start_port) begin
      running <= (run_delay != 0);
      run_n   <= 1;
      if (run_delay == 0) done_port <= 1'b1;
    end else if (running) begin
      run_n <= run_n + 1;
      if (run_n == run_delay) begin
        done_port <= 1'b1;
        running   <= 1'b0;
      end
    end
  end

  // Activity counters on the DUT's outgoing request signals.
  int we_cyc = 0, oe_cyc = 0, start_cyc = 0, field_bad = 0;
  always @(negedge clock) begin
    if (S_we_ram[0]) we_cyc <= we_cyc + 1;
    if (S_oe_ram[0]) oe_cyc <= oe_cyc + 1;
    if (start_port)  start_cyc <= start_cyc + 1;
    if ((S_we_ram[0] || S_oe_ram[0]) &&
        ((S_addr_ram[6:0] != exp_addr) || (S_data_ram_size[3:0] != 4'd8) ||
         (S_we_ram[1] || S_oe_ram[1]) || (S_addr_ram[13:7] != 7'd0) ||
         (S_we_ram[0] && (S_Wdata_ram[7:0] != exp_wdata))))
      field_bad <= field_bad + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push_exp(input logic err, input logic [31:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got err=%0b data=0x%08h expected no response", rsp_err, rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_data", rsp_data, e.data);
          $display("[TB] rsp err=%0b data=0x%08h", rsp_err, rsp_data);
        end
      end
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [7:0] data);
    bit ok = 0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) bound_fail("cmd_accept");
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    $display("[TB] cmd op=%0d addr=0x%02h data=0x%02h", op, addr, data);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if ((exp_q.size() == 0) && !busy) begin ok = 1; break; end
    end
    if (!ok) bound_fail(name);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_start"}, 32'(start_port), 32'd0);
    check({tag, "_oe_we"}, 32'({S_oe_ram, S_we_ram}), 32'd0);
    check({tag, "_addr_wdata_size"}, 32'({S_addr_ram, S_Wdata_ram, S_data_ram_size}), 32'd0);
    check({tag, "_rsp_fields"}, rsp_data | 32'(rsp_err), 32'd0);
  endtask

  int we0, oe0, st0;

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clock);
    #1 check_idle_outputs("reset");
    @(posedge clock); #1 reset = 1'b1;

    // WRITE 0x05 <- 0xA7, DataRdy in the third request cycle
    exp_addr = 7'h05; exp_wdata = 8'hA7; mem_delay = 2;
    we0 = we_cyc; oe0 = oe_cyc;
    push_exp(1'b0, 32'h0);
    send_cmd(2'd0, 7'h05, 8'hA7);
    wait_drain("write1");
    check("write1_we_cycles", 32'(we_cyc - we0), 32'd3);
    check("write1_oe_cycles", 32'(oe_cyc - oe0), 32'd0);

    // READ 0x05, DataRdy in the first request cycle
    mem_delay = 0;
    we0 = we_cyc; oe0 = oe_cyc;
    push_exp(1'b0, 32'h0000_00A7);
    send_cmd(2'd1, 7'h05, 8'h00);
    wait_drain("read1");
    check("read1_oe_cycles", 32'(oe_cyc - oe0), 32'd1);
    check("read1_we_cycles", 32'(we_cyc - we0), 32'd0);

    // RUN, done 9 cycles after start
    run_delay = 9; st0 = start_cyc;
    push_exp(1'b0, 32'd10);
    send_cmd(2'd2, 7'h00, 8'h00);
    wait_drain("run9");
    check("run9_start_cycles", 32'(start_cyc - st0), 32'd1);

    // RUN, done in the start cycle
    run_delay = 0; st0 = start_cyc;
    push_exp(1'b0, 32'd1);
    send_cmd(2'd2, 7'h00, 8'h00);
    wait_drain("run0");
    check("run0_start_cycles", 32'(start_cyc - st0), 32'd1);

    // READ timeout
    exp_addr = 7'h33; mem_delay = -1; oe0 = oe_cyc;
    push_exp(1'b1, 32'h0);
    send_cmd(2'd1, 7'h33, 8'h00);
    wait_drain("read_to");
    check("read_to_oe_cycles", 32'(oe_cyc - oe0), 32'd64);

    // Next commands still accepted
    exp_addr = 7'h7F; exp_wdata = 8'h3C; mem_delay = 1; we0 = we_cyc;
    push_exp(1'b0, 32'h0);
    send_cmd(2'd0, 7'h7F, 8'h3C);
    wait_drain("write2");
    check("write2_we_cycles", 32'(we_cyc - we0), 32'd2);
    mem_delay = 3; oe0 = oe_cyc;
    push_exp(1'b0, 32'h0000_003C);
    send_cmd(2'd1, 7'h7F, 8'h00);
    wait_drain("read2");
    check("read2_oe_cycles", 32'(oe_cyc - oe0), 32'd4);

    // RUN timeout
    run_delay = -1; st0 = start_cyc;
    push_exp(1'b1, 32'(RTO));
    send_cmd(2'd2, 7'h00, 8'h00);
    wait_drain("run_to");
    check("run_to_start_cycles", 32'(start_cyc - st0), 32'd1);

    // Illegal op under back-pressure, with a WRITE waiting behind it
    rsp_ready = 1'b0; we0 = we_cyc; oe0 = oe_cyc;
    push_exp(1'b1, 32'h0);
    send_cmd(2'd3, 7'h11, 8'h22);
    exp_addr = 7'h10; exp_wdata = 8'h55; mem_delay = 0;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 7'h10; cmd_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_err", 32'(rsp_err), 32'd1);
      check("bp_rsp_data", rsp_data, 32'h0);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    check("illegal_no_s_activity", 32'((we_cyc - we0) + (oe_cyc - oe0)), 32'd0);
    push_exp(1'b0, 32'h0);
    @(posedge clock); #1 rsp_ready = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clock);
        if (cmd_ready) begin ok = 1; break; end
      end
      if (!ok) bound_fail("bp_cmd_accept");
    end
    @(posedge clock); #1 cmd_valid = 1'b0;
    $display("[TB] cmd op=0 addr=0x10 data=0x55 (queued behind response)");
    wait_drain("bp_write");
    check("bp_write_we_cycles", 32'(we_cyc - we0), 32'd1);

    // Reset during RUN_WAIT aborts with no response
    run_delay = -1;
    send_cmd(2'd2, 7'h00, 8'h00);
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    #1 check_idle_outputs("midrun_reset");
    repeat (3) @(posedge clock);
    #1 check_idle_outputs("held_reset");
    reset = 1'b1;

    exp_addr = 7'h22; exp_wdata = 8'h99; mem_delay = 1; we0 = we_cyc;
    push_exp(1'b0, 32'h0);
    send_cmd(2'd0, 7'h22, 8'h99);
    wait_drain("post_reset_write");
    check("post_reset_we_cycles", 32'(we_cyc - we0), 32'd2);

    repeat (3) @(negedge clock);
    check("field_stability", 32'(field_bad), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
